keypad_time_entry: RTL and testbench
====================================

Name: keypad_time_entry

Overview:
- Upstream stage of the microwave timer counter chain: seconds-ones mod-10, seconds-tens mod-6, minutes-ones mod-10.
- Captures BCD digits from the keypad encoder and shifts them right-to-left into an m:ss entry.
- On start, it drives the parallel-load data and an active-low load strobe into the counters, then holds their count enable until the chain reports zero or the user cancels.

Parameters:
- DIG_W, 4, width of one BCD digit.
- MAX_TENS, 5, largest legal seconds-tens value; matches the mod-6 counter range 0..5.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clearn  input  1  asynchronous active-low reset.
- key_valid  input  1  level from keypad encoder, high while a key is held.
- key_digit  input  DIG_W  BCD value of the held key; sampled on the key_valid rising edge.
- start  input  1  start button level.
- cancel  input  1  cancel/clear button level.
- timer_zero  input  1  high when the whole counter chain reads 0:00.
- sec_ones  output  DIG_W  entered seconds-ones digit (display and load data).
- sec_tens  output  DIG_W  seconds-tens load data, clamped to MAX_TENS.
- min_ones  output  DIG_W  entered minutes digit (display and load data).
- loadn  output  1  active-low parallel-load strobe to all three counters.
- EN  output  1  count enable to the counter chain.
- busy  output  1  high in LOAD or RUN.

Behaviour:
- Reset (clearn=0, asynchronous):
  - State returns to IDLE.
  - All digit registers go to 0.
  - loadn=1, EN=0, busy=0.
  - Edge-detect registers go to 0.
  - Reset takes effect mid-RUN or mid-LOAD with no further load or count.
- Edge detection:
  - key_prev and start_prev are registered each cycle.
  - key_evt = key_valid & ~key_prev.
  - start_evt = start & ~start_prev.
  - A held key or held start produces exactly one event.
- States:
  - IDLE: no digits entered.
  - ENTRY: at least one digit entered.
  - LOAD: exactly one cycle.
  - RUN: counting.
- Digit capture, in IDLE or ENTRY only, on key_evt with key_digit<=9:
  - min_ones<=raw_tens, raw_tens<=sec_ones, sec_ones<=key_digit.
  - State goes to ENTRY.
  - The fourth and later digits shift the oldest digit out (saturating 3-digit window).
- key_digit>9: the event is consumed and no register changes.
- sec_tens output = min(raw_tens, MAX_TENS), combinational from raw_tens. The raw value is kept internally.
- ENTRY -> LOAD on start_evt when {min_ones, raw_tens, sec_ones} is nonzero.
  - start_evt in IDLE, or with an all-zero entry, is ignored.
- LOAD:
  - loadn=0 for exactly one cycle.
  - Digit outputs are stable throughout.
  - EN=0.
  - Next state is RUN.
- RUN:
  - EN=1, loadn=1.
  - key_evt and start_evt are ignored.
  - RUN -> IDLE when timer_zero=1 (sampled from the second RUN cycle onward, so the stale pre-load zero is ignored). Digits clear to 0 and EN drops on that edge.
- cancel (level, synchronous) in any state:
  - Goes to IDLE, clears digits, EN=0, loadn=1.
  - Priority order: cancel > start_evt > key_evt.
- key_evt and start_evt in the same cycle in ENTRY: the load proceeds with the pre-key digits and the key is dropped.
- Latency:
  - key_evt edge to digit visible: 1 cycle.
  - start_evt edge to loadn low: 1 cycle.
  - loadn low to EN high: 1 cycle.

Decomposition:
- Shared timer package holds:
  - DIG_W and MAX_TENS.
  - The 2-bit state encoding (IDLE=0, ENTRY=1, LOAD=2, RUN=3).
  - The BCD_MAX=9 constant.
- One natural sub-module: rise_detect (1-bit registered rising-edge detector with clearn). Instantiate it twice, for key and start.

Test Plan:
- Reset then press key 1, 2, 3 (each held 3 cycles) -> min_ones=1, sec_tens=2, sec_ones=3, state ENTRY, loadn=1, EN=0.
- Enter 1,7,5 -> raw tens 7, sec_tens output=5. Then start -> loadn low for exactly 1 cycle with {1,5,5}, EN=1 from the next cycle, busy=1.
- Enter 4,2 then key_digit=12 -> digits unchanged (min_ones=0, sec_tens=4, sec_ones=2). Start with no digits from reset -> loadn stays 1, state IDLE.
- In RUN, press key 9 and start -> no change. Assert timer_zero -> next edge EN=0, busy=0, digits 0, state IDLE.
- Enter 9,9,9,8 -> min_ones=9, sec_tens=5 (raw 9), sec_ones=8. Assert cancel together with start -> IDLE, digits 0, loadn never low.
- During RUN, pulse clearn low between clock edges -> outputs reset immediately (EN=0, loadn=1, digits 0). After release, state is IDLE.

Source files
------------

// File: rtl/keypad_time_entry_pkg.sv
// rtl/keypad_time_entry_pkg.sv - shared timer constants, state encoding and tens clamp
// Purpose: constants and types shared by the keypad time-entry block.
//   DIG_W    : width of one BCD digit
//   MAX_TENS : largest legal seconds-tens value (mod-6 counter range 0..5)
//   BCD_MAX  : largest legal BCD key value
//   state_t  : controller state encoding
package keypad_time_entry_pkg;

   localparam int DIG_W = 4;

   localparam logic [DIG_W-1:0] MAX_TENS = DIG_W'(5);
   localparam logic [DIG_W-1:0] BCD_MAX  = DIG_W'(9);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_LOAD  = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   // The seconds-tens counter only counts 0..5, so anything larger is
   // presented to it as 5; the raw keyed value is kept separately.
   function automatic logic [DIG_W-1:0] clamp_tens(input logic [DIG_W-1:0] raw);
      return (raw > MAX_TENS) ? MAX_TENS : raw;
   endfunction

endpackage

// File: rtl/keypad_time_entry_rise_detect.sv
// rtl/keypad_time_entry_rise_detect.sv - registered 1-bit rising-edge detector
// Purpose: one-cycle event on the first cycle a level input is seen high.
// Ports:
//   clk    : system clock
//   clearn : asynchronous active-low reset (previous level forced to 0)
//   level  : input level
//   evt    : level & ~previous level
module keypad_time_entry_rise_detect (
   input  logic clk,
   input  logic clearn,
   input  logic level,
   output logic evt
);

   logic prev_q;

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level;
      end
   end

   assign evt = level & ~prev_q;

endmodule

// File: rtl/keypad_time_entry.sv
// rtl/keypad_time_entry.sv - keypad m:ss entry and load/run control for the timer chain
// Purpose: shifts keyed BCD digits into an m:ss entry, loads the counter
//   chain on start and enables counting until zero or cancel.
// Ports:
//   clk, clearn        : clock, asynchronous active-low reset
//   key_valid/key_digit: keypad level and BCD value
//   start, cancel      : button levels
//   timer_zero         : counter chain reads 0:00
//   sec_ones, sec_tens, min_ones : load/display data (sec_tens clamped)
//   loadn              : active-low parallel-load strobe
//   EN                 : count enable
//   busy               : high while loading or running
module keypad_time_entry
   import keypad_time_entry_pkg::*;
(
   input  logic             clk,
   input  logic             clearn,
   input  logic             key_valid,
   input  logic [DIG_W-1:0] key_digit,
   input  logic             start,
   input  logic             cancel,
   input  logic             timer_zero,
   output logic [DIG_W-1:0] sec_ones,
   output logic [DIG_W-1:0] sec_tens,
   output logic [DIG_W-1:0] min_ones,
   output logic             loadn,
   output logic             EN,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [DIG_W-1:0] sec_ones_q, sec_ones_d;
   logic [DIG_W-1:0] raw_tens_q, raw_tens_d;
   logic [DIG_W-1:0] min_ones_q, min_ones_d;
   logic             run_armed_q;
   logic             key_evt, start_evt;
   logic             key_ok, entry_nz;

   keypad_time_entry_rise_detect u_key_edge (
      .clk    (clk),
      .clearn (clearn),
      .level  (key_valid),
      .evt    (key_evt)
   );

   keypad_time_entry_rise_detect u_start_edge (
      .clk    (clk),
      .clearn (clearn),
      .level  (start),
      .evt    (start_evt)
   );

   assign key_ok   = key_evt && (key_digit <= BCD_MAX);
   assign entry_nz = |{min_ones_q, raw_tens_q, sec_ones_q};

   always_comb begin
      state_d    = state_q;
      sec_ones_d = sec_ones_q;
      raw_tens_d = raw_tens_q;
      min_ones_d = min_ones_q;
      if (cancel) begin
         state_d    = ST_IDLE;
         sec_ones_d = '0;
         raw_tens_d = '0;
         min_ones_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_ENTRY: begin
               // An accepted start wins over a same-cycle key: the load
               // uses the digits already entered.
               if (start_evt && (state_q == ST_ENTRY) && entry_nz) begin
                  state_d = ST_LOAD;
               end else if (key_ok) begin
                  min_ones_d = raw_tens_q;
                  raw_tens_d = sec_ones_q;
                  sec_ones_d = key_digit;
                  state_d    = ST_ENTRY;
               end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
               // The chain still shows its pre-load value during the first
               // RUN cycle, so zero is only trusted once armed.
               if (run_armed_q && timer_zero) begin
                  state_d    = ST_IDLE;
                  sec_ones_d = '0;
                  raw_tens_d = '0;
                  min_ones_d = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         state_q     <= ST_IDLE;
         sec_ones_q  <= '0;
         raw_tens_q  <= '0;
         min_ones_q  <= '0;
         run_armed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sec_ones_q  <= sec_ones_d;
         raw_tens_q  <= raw_tens_d;
         min_ones_q  <= min_ones_d;
         run_armed_q <= (state_q == ST_RUN) && (state_d == ST_RUN);
      end
   end

   assign sec_ones = sec_ones_q;
   assign sec_tens = clamp_tens(raw_tens_q);
   assign min_ones = min_ones_q;
   assign loadn    = (state_q != ST_LOAD);
   assign EN       = (state_q == ST_RUN);
   assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb/tb_keypad_time_entry.sv - self-checking bench for keypad_time_entry
module tb_keypad_time_entry;

   logic       clk = 1'b0;
   logic       clearn = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_digit = 4'd0;
   logic       start = 1'b0;
   logic       cancel = 1'b0;
   logic       timer_zero = 1'b0;
   logic [3:0] sec_ones, sec_tens, min_ones;
   logic       loadn, EN, busy;

   int total = 0;
   int bad = 0;
   int low_cnt = 0;
   int en_cnt = 0;

   // Model: the entry as a decimal number m*100 + t*10 + s.
   int m_entry = 0;
   bit m_load = 0;
   bit m_run = 0;
   int m_age = 0;
   bit m_pk = 0;
   bit m_ps = 0;

   keypad_time_entry dut (
      .clk        (clk),
      .clearn     (clearn),
      .key_valid  (key_valid),
      .key_digit  (key_digit),
      .start      (start),
      .cancel     (cancel),
      .timer_zero (timer_zero),
      .sec_ones   (sec_ones),
      .sec_tens   (sec_tens),
      .min_ones   (min_ones),
      .loadn      (loadn),
      .EN         (EN),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_entry = 0; m_load = 0; m_run = 0; m_age = 0; m_pk = 0; m_ps = 0;
   endtask

   task automatic m_step();
      bit kev, sev;
      kev  = key_valid && !m_pk;
      sev  = start && !m_ps;
      m_pk = key_valid;
      m_ps = start;
      if (cancel) begin
         m_entry = 0; m_load = 0; m_run = 0;
      end else if (m_load) begin
         m_load = 0; m_run = 1; m_age = 0;
      end else if (m_run) begin
         if (m_age >= 1 && timer_zero) begin
            m_run = 0; m_entry = 0;
         end else begin
            m_age++;
         end
      end else if (sev && m_entry != 0) begin
         m_load = 1;
      end else if (kev && key_digit <= 9) begin
         m_entry = (m_entry * 10 + int'(key_digit)) % 1000;
      end
   endtask

   always @(negedge clearn) m_reset();

   always @(posedge clk) begin
      int t;
      if (!clearn) m_reset();
      else m_step();
      #2;
      t = (m_entry / 10) % 10;
      chk("model sec_ones", sec_ones, m_entry % 10);
      chk("model sec_tens", sec_tens, (t > 5) ? 5 : t);
      chk("model min_ones", min_ones, m_entry / 100);
      chk("model loadn", loadn, !m_load);
      chk("model EN", EN, m_run);
      chk("model busy", busy, m_load || m_run);
      if (!loadn) low_cnt++;
      if (EN) en_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int d);
      key_digit = 4'(d);
      key_valid = 1'b1;
      cyc(3);
      key_valid = 1'b0;
      cyc(1);
   endtask

   task automatic do_cancel();
      cancel = 1'b1;
      cyc(1);
      cancel = 1'b0;
      cyc(1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(2);
      start = 1'b0;
      cyc(1);
   endtask

   task automatic digits(input string tag, input int mo, input int st, input int so);
      chk({tag, " min_ones"}, min_ones, mo);
      chk({tag, " sec_tens"}, sec_tens, st);
      chk({tag, " sec_ones"}, sec_ones, so);
   endtask

   initial begin
      int low0, en0;
      cyc(3);
      digits("reset", 0, 0, 0);
      chk("reset loadn", loadn, 1);
      chk("reset EN", EN, 0);
      chk("reset busy", busy, 0);
      clearn = 1'b1;
      cyc(1);

      press(1); press(2); press(3);
      digits("123", 1, 2, 3);
      chk("123 loadn", loadn, 1);
      chk("123 EN", EN, 0);

      do_cancel();
      press(1); press(7); press(5);
      digits("175", 1, 5, 5);
      low0 = low_cnt;
      start = 1'b1;
      cyc(1);
      chk("load loadn", loadn, 0);
      chk("load EN", EN, 0);
      chk("load busy", busy, 1);
      digits("load", 1, 5, 5);
      cyc(1);
      chk("run loadn", loadn, 1);
      chk("run EN", EN, 1);
      start = 1'b0;
      cyc(2);
      chk("one load cycle", low_cnt - low0, 1);

      press(9);
      pulse_start();
      digits("run ignore", 1, 5, 5);
      chk("run ignore EN", EN, 1);
      chk("run ignore loads", low_cnt - low0, 1);
      timer_zero = 1'b1;
      cyc(1);
      chk("zero EN", EN, 0);
      chk("zero busy", busy, 0);
      digits("zero", 0, 0, 0);

      // Stale zero held across the load: two RUN cycles before it is honoured.
      press(2);
      en0 = en_cnt;
      start = 1'b1;
      cyc(4);
      start = 1'b0;
      chk("stale zero EN cycles", en_cnt - en0, 2);
      chk("stale zero busy", busy, 0);
      timer_zero = 1'b0;
      cyc(1);

      press(4); press(2); press(12);
      digits("bad key", 0, 4, 2);
      do_cancel();
      low0 = low_cnt;
      pulse_start();
      chk("idle start busy", busy, 0);
      press(0);
      pulse_start();
      chk("zero entry busy", busy, 0);
      chk("no loads", low_cnt - low0, 0);

      press(9); press(9); press(9); press(8);
      digits("9998", 9, 5, 8);
      cancel = 1'b1;
      start = 1'b1;
      cyc(1);
      cancel = 1'b0;
      cyc(1);
      start = 1'b0;
      cyc(1);
      chk("cancel busy", busy, 0);
      digits("cancel", 0, 0, 0);
      chk("cancel loads", low_cnt - low0, 0);

      press(3);
      key_digit = 4'd4;
      key_valid = 1'b1;
      start = 1'b1;
      cyc(1);
      chk("key+start loadn", loadn, 0);
      digits("key+start", 0, 0, 3);
      cyc(1);
      key_valid = 1'b0;
      start = 1'b0;
      chk("key+start EN", EN, 1);
      do_cancel();
      chk("cancel run busy", busy, 0);

      press(2); press(0); press(0);
      digits("200", 2, 0, 0);
      pulse_start();
      chk("pre-reset EN", EN, 1);
      #1 clearn = 1'b0;
      #1;
      chk("async EN", EN, 0);
      chk("async loadn", loadn, 1);
      chk("async busy", busy, 0);
      digits("async", 0, 0, 0);
      #1 clearn = 1'b1;
      cyc(1);
      chk("post reset busy", busy, 0);
      pulse_start();
      chk("post reset start", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
